// File: rtl/ioctl_loader.sv
// HPS ioctl download engine: maps ioctl_index to a memory region and streams words to SDRAM.
// Define IOCTL_LOADER_CKSUM_EN to add a 16-bit running checksum output.
module ioctl_loader #(
    parameter int ADDR_W      = 25,
    parameter int NUM_REGIONS = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS-1:0]        region_swap,
    input  logic                          ioctl_download,
    input  logic [7:0]                    ioctl_index,
    input  logic                          ioctl_wr,
    input  logic [ADDR_W-1:0]             ioctl_addr,
    input  logic [15:0]                   ioctl_dout,
    output logic                          ioctl_wait,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [15:0]                   mem_wdata,
    input  logic                          mem_ack,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W-1:0]             words_loaded,
    output logic                          bad_index,
`ifdef IOCTL_LOADER_CKSUM_EN
    output logic [15:0]                   checksum,
`endif
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SKIP, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              dl_prev_q;
    logic [ADDR_W-1:0] base_q, base_d, base_sel;
    logic              swap_q, swap_d, swap_sel;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wait_q, wait_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic              bad_q, bad_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
    logic [15:0]       fifo_data_q [FIFO_DEPTH];
    logic [15:0]       fifo_data_d [FIFO_DEPTH];
    logic              start, region_ok, load_start, push, pop, full;
    logic [ADDR_W-1:0] push_addr;
    logic [15:0]       push_data;
    logic              unused_ok;

    assign unused_ok  = &{1'b0, ioctl_index[7:6], ioctl_addr[0]};
    assign start      = ioctl_download & ~dl_prev_q;
    assign region_ok  = ({1'b0, ioctl_index[5:0]} < 7'(NUM_REGIONS));
    assign load_start = (state_q == S_IDLE) & start & region_ok;
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign push       = (state_q == S_LOAD) & ioctl_wr & ~full;
    assign pop        = mem_ack & (count_q != '0);
    assign push_addr  = base_q + {ioctl_addr[ADDR_W-1:1], 1'b0};
    assign push_data  = swap_q ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;

    // Explicit mux avoids an out-of-range part-select for unmapped indices.
    always_comb begin
        base_sel = '0;
        swap_sel = 1'b0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (ioctl_index[5:0] == 6'(r)) begin
                base_sel = region_base[r*ADDR_W +: ADDR_W];
                swap_sel = region_swap[r];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            dl_prev_q   <= 1'b0;
            base_q      <= '0;
            swap_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_q      <= 1'b0;
            words_q     <= '0;
            bad_q       <= 1'b0;
            ovf_q       <= 1'b0;
            fifo_addr_q <= '{default: '0};
            fifo_data_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            dl_prev_q   <= ioctl_download;
            base_q      <= base_d;
            swap_q      <= swap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            words_q     <= words_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = region_ok ? S_LOAD : S_SKIP;
            S_LOAD:  if (!ioctl_download) state_d = S_DRAIN;
            S_SKIP:  if (!ioctl_download) state_d = S_IDLE;
            S_DRAIN: if (count_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_d      = base_q;
        swap_d      = swap_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        words_d     = words_q;
        bad_d       = bad_q;
        ovf_d       = ovf_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        if (load_start) begin
            base_d  = base_sel;
            swap_d  = swap_sel;
            words_d = '0;
        end
        if ((state_q == S_IDLE) && start && !region_ok) bad_d = 1'b1;
        if ((state_q == S_LOAD) && ioctl_wr && full) ovf_d = 1'b1;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = push_addr;
            fifo_data_d[wr_ptr_q] = push_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            words_d  = words_q + ADDR_W'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        wait_d  = (count_d >= CW'(FIFO_DEPTH - 1));
    end

    // Head is gated so the memory bus idles at zero when nothing is queued.
    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        mem_req      = (count_q != '0);
        mem_addr     = mem_req ? fifo_addr_q[rd_ptr_q] : '0;
        mem_wdata    = mem_req ? fifo_data_q[rd_ptr_q] : '0;
        ioctl_wait   = wait_q;
        words_loaded = words_q;
        bad_index    = bad_q;
        overflow     = ovf_q;
    end

`ifdef IOCTL_LOADER_CKSUM_EN
    logic [15:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (load_start) cksum_d = '0;
        else if (pop)   cksum_d = cksum_q + fifo_data_q[rd_ptr_q];
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) cksum_q <= '0;
        else        cksum_q <= cksum_d;
    end

    assign checksum = cksum_q;
`endif
endmodule

// File: tb/tb_ioctl_loader.sv
// Randomized bench for ioctl_loader against a queue-based model of the download rules.
module tb_ioctl_loader;
    localparam int AW = 25;
    localparam int NR = 4;
    localparam int FD = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } ent_t;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] region_base;
    logic [NR-1:0]    region_swap;
    logic             ioctl_download, ioctl_wr, mem_ack;
    logic [7:0]       ioctl_index;
    logic [AW-1:0]    ioctl_addr, mem_addr, words_loaded;
    logic [15:0]      ioctl_dout, mem_wdata;
    logic             ioctl_wait, mem_req, busy, done, bad_index, overflow;
`ifdef IOCTL_LOADER_CKSUM_EN
    logic [15:0]      checksum;
`endif

    ioctl_loader #(.ADDR_W(AW), .NUM_REGIONS(NR), .FIFO_DEPTH(FD)) dut (
        .clk_sys(clk_sys), .reset(reset), .region_base(region_base), .region_swap(region_swap),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .words_loaded(words_loaded), .bad_index(bad_index),
`ifdef IOCTL_LOADER_CKSUM_EN
        .checksum(checksum),
`endif
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_fail = 0, ack_pct = 100;
    ent_t q[$];
    logic m_load = 0, m_swap = 0, m_ovf = 0, m_bad = 0;
    logic [AW-1:0] m_base = '0, m_words = '0;
    logic [15:0]   m_ck = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model, clock.
    task automatic step(input logic wr_i, input logic [AW-1:0] a_i, input logic [15:0] d_i, input int start);
        int   pre, r;
        ent_t e;
        chk("mem_req", mem_req, q.size() != 0);
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].a);
            chk("mem_wdata", mem_wdata, q[0].d);
        end
        chk("ioctl_wait", ioctl_wait, q.size() >= FD - 1);
        chk("overflow", overflow, m_ovf);
        chk("bad_index", bad_index, m_bad);
        chk("words_loaded", words_loaded, m_words);
        ioctl_wr   = wr_i;
        ioctl_addr = a_i;
        ioctl_dout = d_i;
        mem_ack    = ($urandom_range(0, 99) < ack_pct);
        pre = q.size();
        if (start == 1) begin
            r       = int'(ioctl_index[5:0]);
            m_base  = region_base[r*AW +: AW];
            m_swap  = region_swap[r];
            m_load  = 1;
            m_words = '0;
            m_ck    = '0;
        end
        if (start == 2) m_bad = 1;
        if (wr_i && m_load) begin
            if (pre < FD) begin
                e.a = m_base + {a_i[AW-1:1], 1'b0};
                e.d = m_swap ? {d_i[7:0], d_i[15:8]} : d_i;
                q.push_back(e);
            end else m_ovf = 1;
        end
        if (mem_ack && pre != 0) begin
            m_ck = m_ck + q[0].d;
            m_words++;
            void'(q.pop_front());
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 0);
    endtask

    task automatic dl_begin(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        step(1'b0, '0, '0, ({1'b0, idx[5:0]} < 7'(NR)) ? 1 : 2);
        chk("busy_start", busy, 1);
    endtask

    task automatic dl_end(input logic wr_i);
        ioctl_download = 1'b0;
        step(wr_i, AW'($urandom), 16'($urandom), 0);
        m_load = 0;
    endtask

    // done must pulse exactly one cycle after the model queue is empty in drain.
    task automatic drain();
        logic exp = 0;
        bit   seen = 0;
        if (ack_pct == 0) ack_pct = 100;
        for (int k = 0; k < 200 && !seen; k++) begin
            chk("done", done, exp);
            if (exp) seen = 1;
            else begin
                exp = (q.size() == 0);
                step(1'b0, '0, '0, 0);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        chk("words_at_done", words_loaded, m_words);
`ifdef IOCTL_LOADER_CKSUM_EN
        chk("checksum_at_done", checksum, m_ck);
`endif
        step(1'b0, '0, '0, 0);
        chk("done_pulse_end", done, 0);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        reset = 1'b0; region_base = '0; region_swap = '0; ioctl_download = 0;
        ioctl_index = '0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = '0; mem_ack = 0;
        repeat (3) @(negedge clk_sys);
        chk("rst_mem_req", mem_req, 0);   chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0); chk("rst_wait", ioctl_wait, 0);
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_words", words_loaded, 0); chk("rst_bad", bad_index, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        @(negedge clk_sys);

        // Region 0, swapped, immediate ack.
        region_swap = 4'b0001; ack_pct = 100;
        dl_begin(8'h00);
        step(1'b1, 25'h0, 16'h1234, 0);
        chk("t1_addr0", mem_addr, 25'h0); chk("t1_data0", mem_wdata, 16'h3412);
        step(1'b1, 25'h2, 16'hABCD, 0);
        chk("t1_addr1", mem_addr, 25'h2); chk("t1_data1", mem_wdata, 16'hCDAB);
        dl_end(1'b0);
        drain();
        chk("t1_words", words_loaded, 2);

        // Region 2 with odd byte offset, unswapped.
        region_base[2*AW +: AW] = 25'h100000; ack_pct = 0;
        dl_begin(8'h02);
        step(1'b1, 25'h7, 16'h5555, 0);
        chk("t2_addr", mem_addr, 25'h100006); chk("t2_data", mem_wdata, 16'h5555);
        dl_end(1'b0);
        drain();

        // Stalled memory: wait threshold, full FIFO, overflow.
        ack_pct = 0;
        dl_begin(8'h01);
        step(1'b1, 25'h10, 16'h0001, 0);
        step(1'b1, 25'h12, 16'h0002, 0);
        chk("t3_wait_lo", ioctl_wait, 0);
        step(1'b1, 25'h14, 16'h0003, 0);
        chk("t3_wait_hi", ioctl_wait, 1);
        step(1'b1, 25'h16, 16'h0004, 0);
        step(1'b1, 25'h18, 16'h0005, 0);
        chk("t3_ovf", overflow, 1);
        idle(20);
        dl_end(1'b0);
        drain();
        chk("t3_words", words_loaded, 4);

        // Unmapped region: writes are discarded, no done.
        ack_pct = 50;
        dl_begin(8'h05);
        for (int i = 0; i < 10; i++) step(1'b1, AW'($urandom), 16'($urandom), 0);
        dl_end(1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("skip_done", done, 0);
            chk("skip_busy", busy, 0);
            step(1'b0, '0, '0, 0);
        end
        chk("skip_bad", bad_index, 1);

        // Randomized downloads; region inputs are perturbed mid-download.
        for (int n = 0; n < 10; n++) begin
            for (int r = 0; r < NR; r++) region_base[r*AW +: AW] = AW'($urandom);
            region_swap = NR'($urandom);
            ack_pct = 20 + 40 * $urandom_range(0, 2);
            dl_begin({2'($urandom), 6'($urandom_range(0, NR - 1))});
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                step(1'b1, AW'($urandom), 16'($urandom), 0);
                if ($urandom_range(0, 3) == 0) begin
                    region_base = {$urandom, $urandom, $urandom, $urandom};
                    region_swap = ~region_swap;
                    step(1'b0, '0, '0, 0);
                end
            end
            dl_end(1'($urandom));
            drain();
        end

        // Reset mid-drain with entries queued.
        ack_pct = 0;
        dl_begin(8'h03);
        step(1'b1, 25'h20, 16'h1111, 0);
        step(1'b1, 25'h22, 16'h2222, 0);
        dl_end(1'b0);
        chk("t5_queued", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("t5_mem_req", mem_req, 0); chk("t5_busy", busy, 0);
        chk("t5_ovf", overflow, 0);    chk("t5_bad", bad_index, 0);
        chk("t5_words", words_loaded, 0);
        q.delete(); m_load = 0; m_ovf = 0; m_bad = 0; m_words = '0; m_ck = '0;
        @(negedge clk_sys);
        reset = 1'b1;
        ack_pct = 100;
        idle(4);

`ifdef IOCTL_LOADER_CKSUM_EN
        region_swap = '0; ack_pct = 100;
        dl_begin(8'h01);
        step(1'b1, 25'h0, 16'hFFFF, 0);
        step(1'b1, 25'h2, 16'h0002, 0);
        dl_end(1'b0);
        drain();
        chk("cksum", checksum, 16'h0001);
`endif

        ack_pct = 60;
        region_swap = NR'($urandom);
        dl_begin(8'h02);
        for (int i = 0; i < 6; i++) step(1'b1, AW'($urandom), 16'($urandom), 0);
        dl_end(1'b1);
        drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/ioctl_loader.md
Name: ioctl_loader

Overview:
Synthesizable HPS-ioctl-to-SDRAM download engine that replaces testbench-side backdoor ROM loading with a real data path. It maps each ioctl_index to one of NUM_REGIONS memory regions, each with its own base address and endian swap. A small FIFO decouples ioctl writes from the SDRAM controller's request/ack port. It sits between hps_io and the sdram arbiter in mycore.

Parameters:
ADDR_W, 25, byte address width on both ioctl and memory sides
NUM_REGIONS, 4, number of index-mapped regions (1..64)
FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2)

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-low reset
region_base  in  NUM_REGIONS*ADDR_W  per-region byte base; region r at bits [r*ADDR_W +: ADDR_W]; quasi-static
region_swap  in  NUM_REGIONS  1 = swap bytes of each word for that region
ioctl_download  in  1  download active
ioctl_index  in  8  [5:0] = region number; [7:6] ignored
ioctl_wr  in  1  one-cycle write strobe
ioctl_addr  in  ADDR_W  byte offset within file
ioctl_dout  in  16  write data
ioctl_wait  out  1  backpressure to hps_io
mem_req  out  1  write request to SDRAM port
mem_addr  out  ADDR_W  word-aligned byte address (bit0 = 0)
mem_wdata  out  16  write data
mem_ack  in  1  one-cycle accept of the current request
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a download has fully drained
words_loaded  out  ADDR_W  words committed to memory in current/last download
bad_index  out  1  sticky: download started with region >= NUM_REGIONS
overflow  out  1  sticky: ioctl_wr accepted while FIFO full

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty; all outputs 0, including words_loaded and sticky flags.
- States: IDLE, LOAD, SKIP, DRAIN, DONE.
- IDLE: on ioctl_download 0->1, latch region = ioctl_index[5:0].
  - region < NUM_REGIONS -> LOAD; latch base and swap; clear words_loaded.
  - otherwise -> SKIP; set bad_index.
- LOAD:
  - ioctl_wr pushes {region_base + {ioctl_addr[ADDR_W-1:1],1'b0} (mod 2^ADDR_W), swap ? {dout[7:0],dout[15:8]} : dout}.
  - ioctl_download 0 -> DRAIN. A write in that same cycle is still pushed.
- SKIP: writes discarded; ioctl_wait=0; ioctl_download 0 -> IDLE. No done pulse.
- DRAIN: FIFO empty and no request pending -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- ioctl_wait = (fifo_count >= FIFO_DEPTH-1), registered; asserts the cycle after the push that reaches threshold.
- Write while FIFO full: data dropped; overflow set.
- Write with simultaneous pop: count unchanged.
- Memory handshake:
  - mem_req=1 whenever FIFO is non-empty; mem_addr and mem_wdata present the FIFO head and are held stable until mem_ack.
  - On mem_ack: pop; words_loaded+1 (wraps at 2^ADDR_W). mem_req stays high if further entries remain; the next head appears the following cycle.
  - mem_ack while mem_req=0 is ignored.
- Minimum latency ioctl_wr -> mem_req: 1 cycle (FIFO registered).
- ioctl_download re-rising in DRAIN/DONE is ignored until IDLE; hps_io honors busy.
- Region inputs are sampled only at IDLE->LOAD; changes mid-download have no effect.

Optional Feature:
IOCTL_LOADER_CKSUM_EN: adds output checksum[15:0].
- Cleared on IDLE->LOAD; adds mem_wdata (mod 2^16) on each mem_ack.
- Valid when done pulses; holds until the next download starts.
- Without the macro: port absent, no adder logic.

Test Plan:
- Region 0, base 0, swap=1: writes 0x1234@0, 0xABCD@2, mem_ack immediate -> mem writes (0x0000,0x3412), (0x0002,0xCDAB); done one cycle after last ack; words_loaded=2.
- Region 2, base 0x100000: write 0x5555@0x0007 -> mem_addr 0x100006, data unswapped when region_swap[2]=0.
- mem_ack held low for 20 cycles, 4 back-to-back writes, FIFO_DEPTH=4:
  - ioctl_wait rises after 3rd push; a 4th write fills the FIFO, a 5th sets overflow.
  - Release ack -> 4 ordered writes, then done.
- ioctl_index=0x05 with NUM_REGIONS=4 -> SKIP; 10 writes produce no mem_req; bad_index=1; no done.
- reset driven low mid-DRAIN with 2 entries queued -> mem_req, busy and flags 0 immediately; FIFO empty after release.
- With IOCTL_LOADER_CKSUM_EN: words 0xFFFF, 0x0002 -> checksum=0x0001 at done.
